// File: rtl/index_tone_gen.sv
// index_tone_gen: turns an FFT bin index k into a frame-coherent offset-binary
// sine stream (phase = k*n mod 2^FFT_LEN_LOG2). Used as loop-back stimulus for
// the FFT peak-index detector. New indices take effect only on frame boundaries.
module index_tone_gen #(
  parameter int FFT_LEN_LOG2 = 8,
  parameter int DATA_W       = 12,
  parameter int AMP_SHIFT    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic [FFT_LEN_LOG2-1:0] index_in,
  input  logic                    index_valid,
  output logic                    index_ready,
  output logic [DATA_W-1:0]       tx_out,
  output logic                    valid_out,
  output logic                    frame_start,
  output logic                    ce_out
);

  localparam int L      = FFT_LEN_LOG2;
  localparam int SINE_W = 12;
  localparam logic [L-1:0] N_LAST = '1;
  localparam logic signed [DATA_W:0] MID = (DATA_W+1)'(2 ** (DATA_W - 1));

  // Quarter-wave table: round(2047*sin(2*pi*i/256)), i = 0..64.
  function automatic logic signed [SINE_W-1:0] quarter_rom(input logic [6:0] addr);
    logic signed [SINE_W-1:0] r;
    case (addr)
      7'd0:  r = 12'sd0;    7'd1:  r = 12'sd50;   7'd2:  r = 12'sd100;  7'd3:  r = 12'sd151;
      7'd4:  r = 12'sd201;  7'd5:  r = 12'sd251;  7'd6:  r = 12'sd300;  7'd7:  r = 12'sd350;
      7'd8:  r = 12'sd399;  7'd9:  r = 12'sd449;  7'd10: r = 12'sd497;  7'd11: r = 12'sd546;
      7'd12: r = 12'sd594;  7'd13: r = 12'sd642;  7'd14: r = 12'sd690;  7'd15: r = 12'sd737;
      7'd16: r = 12'sd783;  7'd17: r = 12'sd830;  7'd18: r = 12'sd875;  7'd19: r = 12'sd920;
      7'd20: r = 12'sd965;  7'd21: r = 12'sd1009; 7'd22: r = 12'sd1052; 7'd23: r = 12'sd1095;
      7'd24: r = 12'sd1137; 7'd25: r = 12'sd1179; 7'd26: r = 12'sd1219; 7'd27: r = 12'sd1259;
      7'd28: r = 12'sd1299; 7'd29: r = 12'sd1337; 7'd30: r = 12'sd1375; 7'd31: r = 12'sd1411;
      7'd32: r = 12'sd1447; 7'd33: r = 12'sd1483; 7'd34: r = 12'sd1517; 7'd35: r = 12'sd1550;
      7'd36: r = 12'sd1582; 7'd37: r = 12'sd1614; 7'd38: r = 12'sd1644; 7'd39: r = 12'sd1674;
      7'd40: r = 12'sd1702; 7'd41: r = 12'sd1729; 7'd42: r = 12'sd1756; 7'd43: r = 12'sd1781;
      7'd44: r = 12'sd1805; 7'd45: r = 12'sd1828; 7'd46: r = 12'sd1850; 7'd47: r = 12'sd1871;
      7'd48: r = 12'sd1891; 7'd49: r = 12'sd1910; 7'd50: r = 12'sd1927; 7'd51: r = 12'sd1944;
      7'd52: r = 12'sd1959; 7'd53: r = 12'sd1973; 7'd54: r = 12'sd1986; 7'd55: r = 12'sd1997;
      7'd56: r = 12'sd2008; 7'd57: r = 12'sd2017; 7'd58: r = 12'sd2025; 7'd59: r = 12'sd2032;
      7'd60: r = 12'sd2037; 7'd61: r = 12'sd2041; 7'd62: r = 12'sd2045; 7'd63: r = 12'sd2046;
      default: r = 12'sd2047;
    endcase
    return r;
  endfunction

  // Full-cycle sine from an 8-bit phase by quadrant folding of the table.
  function automatic logic signed [SINE_W-1:0] sine_lookup(input logic [7:0] p);
    logic [1:0] q;
    logic [6:0] addr;
    logic signed [SINE_W-1:0] r;
    q    = p[7:6];
    addr = q[0] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    r    = quarter_rom(addr);
    return q[1] ? -r : r;
  endfunction

  // Scale and shift to offset binary; |s| <= 2047 keeps the result in 1..4095.
  function automatic logic [DATA_W-1:0] to_offset_binary(input logic signed [SINE_W-1:0] s);
    logic signed [DATA_W:0] ext;
    logic signed [DATA_W:0] sum;
    ext = {{(DATA_W + 1 - SINE_W){s[SINE_W-1]}}, s};
    sum = MID + (ext >>> AMP_SHIFT);
    return sum[DATA_W-1:0];
  endfunction

  logic [L-1:0] n_p0_q, n_p0_d, phase_p0_q, phase_p0_d;
  logic [L-1:0] inc_q, inc_d, pend_idx_q, pend_idx_d;
  logic         pending_q, pending_d;
  logic signed [SINE_W-1:0] s_p1_q, s_p1_d;
  logic         fs_p1_q, fs_p1_d, vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] tx_p2_q, tx_p2_d;
  logic         fs_p2_q, fs_p2_d, vld_p2_q, vld_p2_d;
  logic         boundary, take;

  assign boundary = (n_p0_q == N_LAST);
  assign take     = index_valid && !pending_q;

  // Next-state for index handshake and all three pipeline stages; holds when disabled.
  always_comb begin
    n_p0_d     = n_p0_q;
    phase_p0_d = phase_p0_q;
    inc_d      = inc_q;
    pend_idx_d = pend_idx_q;
    pending_d  = pending_q;
    s_p1_d     = s_p1_q;
    fs_p1_d    = fs_p1_q;
    vld_p1_d   = vld_p1_q;
    tx_p2_d    = tx_p2_q;
    fs_p2_d    = fs_p2_q;
    vld_p2_d   = vld_p2_q;
    if (clk_enable) begin
      // stage 0: sample counter, phase accumulator, index commit at frame boundary
      n_p0_d = n_p0_q + L'(1);
      if (boundary) begin
        phase_p0_d = '0;
        if (pending_q) begin
          inc_d     = pend_idx_q;
          pending_d = 1'b0;
        end
      end else begin
        phase_p0_d = phase_p0_q + inc_q;
      end
      // an index accepted on the boundary cycle waits for the next boundary
      if (take) begin
        pend_idx_d = index_in;
        pending_d  = 1'b1;
      end
      // stage 1: quarter-wave lookup
      s_p1_d   = sine_lookup(phase_p0_q[L-1 -: 8]);
      fs_p1_d  = (n_p0_q == '0);
      vld_p1_d = 1'b1;
      // stage 2: offset-binary output
      tx_p2_d  = to_offset_binary(s_p1_q);
      fs_p2_d  = fs_p1_q;
      vld_p2_d = vld_p1_q;
    end
  end

  // State registers; reset restarts the frame at n=0 with inc=0 and mid-scale output.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_p0_q     <= '0;
      phase_p0_q <= '0;
      inc_q      <= '0;
      pend_idx_q <= '0;
      pending_q  <= 1'b0;
      s_p1_q     <= '0;
      fs_p1_q    <= 1'b0;
      vld_p1_q   <= 1'b0;
      tx_p2_q    <= MID[DATA_W-1:0];
      fs_p2_q    <= 1'b0;
      vld_p2_q   <= 1'b0;
    end else begin
      n_p0_q     <= n_p0_d;
      phase_p0_q <= phase_p0_d;
      inc_q      <= inc_d;
      pend_idx_q <= pend_idx_d;
      pending_q  <= pending_d;
      s_p1_q     <= s_p1_d;
      fs_p1_q    <= fs_p1_d;
      vld_p1_q   <= vld_p1_d;
      tx_p2_q    <= tx_p2_d;
      fs_p2_q    <= fs_p2_d;
      vld_p2_q   <= vld_p2_d;
    end
  end

  assign index_ready = !pending_q;
  assign tx_out      = tx_p2_q;
  assign valid_out   = vld_p2_q;
  assign frame_start = fs_p2_q;
  assign ce_out      = clk_enable;

endmodule
